// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state type and sizing constants for the data-memory controller
package dmem_pkg;
  localparam int DFLT_DATA_W = 32;
  localparam int DFLT_DEPTH = 64;
  localparam int BYTES = DFLT_DATA_W / 8;
  localparam int OFFS_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DFLT_DEPTH);
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-addressed RAM with per-byte write enables, synchronous write, combinational read
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   widx,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   ridx,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // byte-lane writes; contents survive reset
  always_ff @(posedge clk)
    for (int b = 0; b < DATA_W / 8; b++)
      if (we && be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[ridx];
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked data-memory controller with wait states, byte-enable writes and access-error detection
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = DFLT_DATA_W,
  parameter int DEPTH = DFLT_DEPTH,
  parameter int WAIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);
  localparam int OW = $clog2(DATA_W / 8);
  localparam int IW = $clog2(DEPTH);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic l_we;
  logic [DATA_W/8-1:0] l_be;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [ADDR_W-1:0] src_addr;
  logic src_we, bad, fin;
  // with zero wait states the completion is resolved straight from the live inputs
  assign src_addr = (state == ST_IDLE) ? addr : l_addr;
  assign src_we = (state == ST_IDLE) ? we : l_we;
  assign bad = (|src_addr[OW-1:0]) || (ADDR_W'(src_addr[ADDR_W-1:OW]) >= ADDR_W'(DEPTH));
  assign fin = (state == ST_IDLE && req && WAIT == 0) || (state == ST_WAIT && cnt == '0);
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(state == ST_RESP && l_we && !err),
    .be(l_be),
    .widx(l_addr[OW +: IW]),
    .wdata(l_wdata),
    .ridx(src_addr[OW +: IW]),
    .rdata(arr_rdata)
  );
  // access sequencer: accept in IDLE, count wait states, complete in RESP
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_be <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      rdata <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          l_we <= we;
          l_be <= be;
          l_addr <= addr;
          l_wdata <= wdata;
          busy <= 1'b1;
          cnt <= CNT_W'(WAIT - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: cnt <= cnt - 1'b1;
        default: begin
          state <= ST_IDLE;
          ready <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
        end
      endcase
      if (fin) begin
        state <= ST_RESP;
        ready <= 1'b1;
        err <= bad;
        rdata <= bad ? '0 : (src_we ? rdata : arr_rdata);
      end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl (WAIT=2 and WAIT=0 builds) against a transaction model
module tb_dmem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req [2];
  logic we [2];
  logic [3:0] be [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic ready [2];
  logic err [2];
  logic busy [2];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int WV = g ? 0 : 2;
    dmem_ctrl #(.WAIT(WV)) dut (
      .clk(clk), .reset(reset), .req(req[g]), .we(we[g]), .be(be[g]),
      .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]), .ready(ready[g]),
      .err(err[g]), .busy(busy[g])
    );
    logic [31:0] mem [64];
    bit known [64];
    int rem = 0;
    logic p_we = 1'b0;
    logic [3:0] p_be = '0;
    logic [31:0] p_addr = '0, p_wd = '0;
    bit p_err = 1'b0;
    logic [31:0] e_rd = '0;
    bit e_known = 1'b1;
    // transaction model: an access occupies WAIT+1 cycles after acceptance, the last being the response
    initial forever begin
      int prev;
      int idx;
      @(posedge clk or negedge reset);
      prev = rem;
      idx = int'(p_addr[7:2]);
      if (!reset) begin
        rem = 0;
        e_rd = '0;
        e_known = 1'b1;
      end else if (rem == 0) begin
        if (req[g]) begin
          p_we = we[g]; p_be = be[g]; p_addr = addr[g]; p_wd = wdata[g];
          p_err = (p_addr[1:0] != 2'b00) || (p_addr[31:2] >= 30'd64);
          rem = WV + 1;
        end
      end else begin
        if (rem == 1 && p_we && !p_err) begin
          for (int b = 0; b < 4; b++) if (p_be[b]) mem[idx][8*b +: 8] = p_wd[8*b +: 8];
          known[idx] = known[idx] || (p_be == 4'hF);
        end
        rem--;
      end
      idx = int'(p_addr[7:2]);
      if (reset && rem == 1 && prev != 1) begin
        if (p_err) begin
          e_rd = '0;
          e_known = 1'b1;
        end else if (!p_we) begin
          e_rd = mem[idx];
          e_known = known[idx];
        end
      end
    end
    initial forever begin
      @(negedge clk);
      if (reset) begin
        chk($sformatf("busy%0d", g), busy[g], rem > 0);
        chk($sformatf("ready%0d", g), ready[g], rem == 1);
        chk($sformatf("err%0d", g), err[g], rem == 1 && p_err);
        if (e_known) chk($sformatf("rdata%0d", g), rdata[g], e_rd);
      end
    end
  end

  task automatic acc(input int i, input bit w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output bit er, output int lat);
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    lat = 0; rd = '0; er = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      #1 req[i] = 1'b0; we[i] = 1'($urandom); be[i] = 4'($urandom); addr[i] = $urandom; wdata[i] = $urandom;
      @(negedge clk);
      if (ready[i]) begin
        rd = rdata[i];
        er = err[i];
        return;
      end
    end
    vectors++;
    miscompares++;
    lat = -1;
    $display("FAIL timeout: no ready on inst %0d within 20 cycles", i);
  endtask

  task automatic hold(input int i, input logic [31:0] a, input int n, output int cnt, output int first, output int last,
                      output logic [31:0] lrd);
    @(negedge clk);
    req[i] = 1'b1; we[i] = 1'b0; be[i] = 4'hF; addr[i] = a;
    cnt = 0; first = 0; last = 0; lrd = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (ready[i]) begin
        if (cnt == 0) first = k;
        last = k;
        cnt++;
        lrd = rdata[i];
      end
    end
    req[i] = 1'b0;
  endtask

  function automatic logic [31:0] raddr(input int i);
    logic [31:0] a;
    int r;
    r = $urandom_range(0, 9);
    a = 32'($urandom_range(0, i ? 15 : 63)) << 2;
    if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
    if (r == 1) a = 32'($urandom_range(64, 2000)) << 2;
    return a;
  endfunction

  initial begin
    logic [31:0] rd;
    bit er;
    int lat, cnt, fp, lp, nr;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; be[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy[i], 1'b0);
      chk("rst_ready", ready[i], 1'b0);
      chk("rst_err", err[i], 1'b0);
      chk("rst_rdata", rdata[i], 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 64; k++) acc(0, 1'b1, 4'hF, 32'(k * 4), (k == 2) ? 32'h0 : $urandom, rd, er, lat);
    acc(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("t1_wr_lat", lat, 3);
    chk("t1_wr_err", er, 1'b0);
    acc(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_data", rd, 32'hDEADBEEF);
    acc(0, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, er, lat);
    acc(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er, lat);
    acc(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
    chk("t2_be_data", rd, 32'h11BB33DD);
    acc(0, 1'b1, 4'hF, 32'h0, 32'hCAFE0000, rd, er, lat);
    acc(0, 1'b0, 4'h0, 32'h13, 32'h0, rd, er, lat);
    chk("t3_mis_err", er, 1'b1);
    chk("t3_mis_data", rd, 32'h0);
    acc(0, 1'b1, 4'hF, 32'h100, 32'h55555555, rd, er, lat);
    chk("t3_oor_err", er, 1'b1);
    acc(0, 1'b0, 4'h0, 32'h0, 32'h0, rd, er, lat);
    chk("t3_idx0", rd, 32'hCAFE0000);
    chk("t3_idx0_err", er, 1'b0);
    hold(0, 32'h10, 12, cnt, fp, lp, rd);
    chk("t4_count", cnt, 3);
    chk("t4_period", (lp - fp) / 2, 4);
    chk("t4_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h08; wdata[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5_busy", busy[0], 1'b0);
    chk("t5_ready", ready[0], 1'b0);
    chk("t5_err", err[0], 1'b0);
    chk("t5_rdata", rdata[0], 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nr = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready[0]) nr++;
    end
    chk("t5_no_ready", nr, 0);
    acc(0, 1'b0, 4'h0, 32'h08, 32'h0, rd, er, lat);
    chk("t5_kept", rd, 32'h0);
    acc(1, 1'b1, 4'hF, 32'h04, 32'h01020304, rd, er, lat);
    chk("t6_wr_lat", lat, 1);
    acc(1, 1'b0, 4'h0, 32'h04, 32'h0, rd, er, lat);
    chk("t6_rd_lat", lat, 1);
    chk("t6_rd_data", rd, 32'h01020304);
    hold(1, 32'h04, 6, cnt, fp, lp, rd);
    chk("t6_count", cnt, 3);
    chk("t6_period", (lp - fp) / 2, 2);
    chk("t6_data", rd, 32'h01020304);
    for (int i = 0; i < 2; i++) begin
      repeat (400) begin
        @(negedge clk);
        req[i] = ($urandom_range(0, 2) != 0);
        we[i] = 1'($urandom);
        be[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        addr[i] = raddr(i);
        wdata[i] = $urandom;
      end
      @(negedge clk);
      req[i] = 1'b0;
      repeat (6) @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
